// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle around cpu_bus_arbiter: CPU instruction/data buses, shared memory port, error flag.
// slave is the arbiter's view; master is the surrounding CPU + memory view.
interface cpu_bus_arbiter_if;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

  logic           cpui_request;
  logic [AW-1:0]  cpui_addr;
  logic [DW-1:0]  cpui_rdata;
  logic           cpui_ack;

  logic           cpud_request;
  logic [AW-1:0]  cpud_addr;
  logic           cpud_write;
  logic [BEW-1:0] cpud_byte_enable;
  logic [DW-1:0]  cpud_wdata;
  logic [DW-1:0]  cpud_rdata;
  logic           cpud_ack;

  logic           mem_request;
  logic [AW-1:0]  mem_addr;
  logic           mem_write;
  logic [BEW-1:0] mem_byte_enable;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           mem_ack;

  logic           bus_error;

  modport slave (
    input  cpui_request, cpui_addr,
    input  cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata,
    input  mem_rdata, mem_ack,
    output cpui_rdata, cpui_ack, cpud_rdata, cpud_ack,
    output mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
    output bus_error
  );

  modport master (
    output cpui_request, cpui_addr,
    output cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata,
    output mem_rdata, mem_ack,
    input  cpui_rdata, cpui_ack, cpud_rdata, cpud_ack,
    input  mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
    input  bus_error
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Merges CPU instruction and data buses onto one memory port, one transaction at a time,
// data bus preferred; flags protocol violations and memory timeouts on a sticky bus_error.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic              clock,
  input logic              reset,
  cpu_bus_arbiter_if.slave bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BEW = 4;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] TIMEOUT_DATA = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {S_IDLE, S_BUSY_D, S_BUSY_I} state_t;

  state_t         r_state;
  logic           r_i_pend;
  logic [AW-1:0]  r_i_addr;
  logic           r_d_pend;
  logic [AW-1:0]  r_d_addr;
  logic           r_d_write;
  logic [BEW-1:0] r_d_be;
  logic [DW-1:0]  r_d_wdata;
  logic [CW-1:0]  r_cnt;
  logic           r_quiet;
  logic           r_mem_request;
  logic [AW-1:0]  r_mem_addr;
  logic           r_mem_write;
  logic [BEW-1:0] r_mem_be;
  logic [DW-1:0]  r_mem_wdata;
  logic           r_i_ack;
  logic [DW-1:0]  r_i_rdata;
  logic           r_d_ack;
  logic [DW-1:0]  r_d_rdata;
  logic           r_bus_error;

  logic           w_busy;
  logic           w_timeout;
  logic           w_done;
  logic           w_arb;
  logic           w_i_acc;
  logic           w_d_acc;
  logic           w_issue_i;
  logic           w_issue_d;
  logic           w_error;
  logic [DW-1:0]  w_ret_data;
  logic [AW-1:0]  w_i_addr;
  logic [AW-1:0]  w_d_addr;
  logic           w_d_write;
  logic [BEW-1:0] w_d_be;
  logic [DW-1:0]  w_d_wdata;

  // A slot is free again in the cycle its transaction completes, so a pulse then is accepted.
  assign w_busy    = (r_state != S_IDLE);
  assign w_timeout = w_busy && !bus.mem_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_done    = w_busy && (bus.mem_ack || w_timeout);
  assign w_arb     = !w_busy || w_done;
  assign w_i_acc   = bus.cpui_request && !r_i_pend && !((r_state == S_BUSY_I) && !w_done);
  assign w_d_acc   = bus.cpud_request && !r_d_pend && !((r_state == S_BUSY_D) && !w_done);

  // Freshly accepted pulses bypass the slot so an empty arbiter issues on the next edge.
  assign w_issue_d = w_arb && (r_state != S_BUSY_D) && (r_d_pend || w_d_acc);
  assign w_issue_i = w_arb && (r_state != S_BUSY_I) && !w_issue_d && (r_i_pend || w_i_acc);

  assign w_i_addr  = r_i_pend ? r_i_addr  : bus.cpui_addr;
  assign w_d_addr  = r_d_pend ? r_d_addr  : bus.cpud_addr;
  assign w_d_write = r_d_pend ? r_d_write : bus.cpud_write;
  assign w_d_be    = r_d_pend ? r_d_be    : bus.cpud_byte_enable;
  assign w_d_wdata = r_d_pend ? r_d_wdata : bus.cpud_wdata;

  assign w_ret_data = bus.mem_ack ? bus.mem_rdata : TIMEOUT_DATA;
  assign w_error    = (bus.cpui_request && !w_i_acc) || (bus.cpud_request && !w_d_acc) ||
                      w_timeout || (!w_busy && bus.mem_ack && !r_quiet);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_i_pend      <= 1'b0;
      r_i_addr      <= '0;
      r_d_pend      <= 1'b0;
      r_d_addr      <= '0;
      r_d_write     <= 1'b0;
      r_d_be        <= '0;
      r_d_wdata     <= '0;
      r_cnt         <= '0;
      r_quiet       <= 1'b1;
      r_mem_request <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_write   <= 1'b0;
      r_mem_be      <= '0;
      r_mem_wdata   <= '0;
      r_i_ack       <= 1'b0;
      r_i_rdata     <= '0;
      r_d_ack       <= 1'b0;
      r_d_rdata     <= '0;
      r_bus_error   <= 1'b0;
    end else begin
      r_mem_request <= 1'b0;
      r_i_ack       <= 1'b0;
      r_d_ack       <= 1'b0;
      if (w_error) r_bus_error <= 1'b1;
      if (w_busy)  r_cnt <= r_cnt + CW'(1);

      if (w_i_acc) begin
        r_i_pend <= 1'b1;
        r_i_addr <= bus.cpui_addr;
      end
      if (w_d_acc) begin
        r_d_pend  <= 1'b1;
        r_d_addr  <= bus.cpud_addr;
        r_d_write <= bus.cpud_write;
        r_d_be    <= bus.cpud_byte_enable;
        r_d_wdata <= bus.cpud_wdata;
      end

      if (w_done) begin
        r_state <= S_IDLE;
        if (r_state == S_BUSY_D) begin
          r_d_ack   <= 1'b1;
          r_d_rdata <= w_ret_data;
        end else begin
          r_i_ack   <= 1'b1;
          r_i_rdata <= w_ret_data;
        end
      end

      // Issue clears the slot's pending bit; reset quiet period ends with the first issue.
      if (w_issue_d) begin
        r_state       <= S_BUSY_D;
        r_d_pend      <= 1'b0;
        r_mem_request <= 1'b1;
        r_cnt         <= '0;
        r_quiet       <= 1'b0;
        r_mem_addr    <= w_d_addr;
        r_mem_write   <= w_d_write;
        r_mem_be      <= w_d_be;
        r_mem_wdata   <= w_d_wdata;
      end else if (w_issue_i) begin
        r_state       <= S_BUSY_I;
        r_i_pend      <= 1'b0;
        r_mem_request <= 1'b1;
        r_cnt         <= '0;
        r_quiet       <= 1'b0;
        r_mem_addr    <= w_i_addr;
        r_mem_write   <= 1'b0;
        r_mem_be      <= '1;
        r_mem_wdata   <= '0;
      end
    end
  end

  assign bus.cpui_rdata      = r_i_rdata;
  assign bus.cpui_ack        = r_i_ack;
  assign bus.cpud_rdata      = r_d_rdata;
  assign bus.cpud_ack        = r_d_ack;
  assign bus.mem_request     = r_mem_request;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_write       = r_mem_write;
  assign bus.mem_byte_enable = r_mem_be;
  assign bus.mem_wdata       = r_mem_wdata;
  assign bus.bus_error       = r_bus_error;
endmodule
